// File: rtl/sat_counter_predictor_if.sv
// Fetch/resolve side bundle for the saturating-counter branch predictor.
// master = fetch + resolution logic, slave = predictor.
interface sat_counter_predictor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 4
);
  logic                  request;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  prediction;
  logic                  pred_strong;
  logic [INDEX_BITS-1:0] pred_index;
  logic                  pred_valid;
  logic                  result;
  logic [INDEX_BITS-1:0] upd_index;
  logic                  taken;

  modport master (
    output request, req_addr, result, upd_index, taken,
    input  prediction, pred_strong, pred_index, pred_valid
  );

  modport slave (
    input  request, req_addr, result, upd_index, taken,
    output prediction, pred_strong, pred_index, pred_valid
  );
endinterface

// File: rtl/sat_counter_predictor.sv
// Table of saturating counters predicting branch direction, with optional
// gshare indexing. One request and one training update per cycle.
module sat_counter_predictor_entry #(
  parameter int CTR_WIDTH = 2,
  parameter int INIT_CTR  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd,
  input  logic                 taken,
  output logic [CTR_WIDTH-1:0] ctr
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr <= CTR_WIDTH'(INIT_CTR);
    end else if (upd) begin
      if (taken && (ctr != '1))
        ctr <= ctr + 1'b1;
      else if (!taken && (ctr != '0))
        ctr <= ctr - 1'b1;
    end
  end
endmodule

module sat_counter_predictor #(
  parameter int CTR_WIDTH  = 2,
  parameter int INDEX_BITS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_LSB   = 2,
  parameter int HIST_BITS  = 0,
  parameter int INIT_CTR   = 2**CTR_WIDTH - 1
) (
  input logic                   clk,
  input logic                   rst,
  sat_counter_predictor_if.slave bus
);
  localparam int NUM_ENT = 1 << INDEX_BITS;

  logic [NUM_ENT-1:0][CTR_WIDTH-1:0] ctrs;
  logic [INDEX_BITS-1:0]             hist_ext;
  logic [INDEX_BITS-1:0]             idx;
  logic [CTR_WIDTH-1:0]              rd_ctr;

  logic                  pred_q;
  logic                  strong_q;
  logic [INDEX_BITS-1:0] index_q;
  logic                  valid_q;

  genvar g;
  generate
    for (g = 0; g < NUM_ENT; g++) begin : g_ent
      sat_counter_predictor_entry #(
        .CTR_WIDTH (CTR_WIDTH),
        .INIT_CTR  (INIT_CTR)
      ) u_ent (
        .clk   (clk),
        .rst   (rst),
        .upd   (bus.result && (bus.upd_index == INDEX_BITS'(g))),
        .taken (bus.taken),
        .ctr   (ctrs[g])
      );
    end

    if (HIST_BITS > 0) begin : g_hist
      logic [HIST_BITS-1:0] ghr;
      // Truncating cast keeps the shift well-formed for a 1-bit history too.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)             ghr <= '0;
        else if (bus.result) ghr <= HIST_BITS'({ghr, bus.taken});
      end
      assign hist_ext = INDEX_BITS'(ghr);
    end else begin : g_nohist
      assign hist_ext = '0;
    end
  endgenerate

  // Reads see pre-update counters and pre-shift history of the same edge.
  assign idx    = bus.req_addr[ADDR_LSB +: INDEX_BITS] ^ hist_ext;
  assign rd_ctr = ctrs[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_q   <= 1'b0;
      strong_q <= 1'b0;
      index_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= bus.request;
      if (bus.request) begin
        pred_q   <= rd_ctr[CTR_WIDTH-1];
        strong_q <= (rd_ctr == '0) || (rd_ctr == '1);
        index_q  <= idx;
      end
    end
  end

  assign bus.prediction  = pred_q;
  assign bus.pred_strong = strong_q;
  assign bus.pred_index  = index_q;
  assign bus.pred_valid  = valid_q;
endmodule

// File: tb/tb_sat_counter_predictor.sv
// Directed bench: default bimodal, 2-bit gshare and 3-bit zero-init predictors.
module tb_sat_counter_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   npass = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  sat_counter_predictor_if #(.ADDR_WIDTH(32), .INDEX_BITS(4)) a0 ();
  sat_counter_predictor_if #(.ADDR_WIDTH(32), .INDEX_BITS(4)) a1 ();
  sat_counter_predictor_if #(.ADDR_WIDTH(32), .INDEX_BITS(4)) a2 ();

  sat_counter_predictor u0 (.clk(clk), .rst(rst), .bus(a0));
  sat_counter_predictor #(.HIST_BITS(2)) u1 (.clk(clk), .rst(rst), .bus(a1));
  sat_counter_predictor #(.CTR_WIDTH(3), .INIT_CTR(0)) u2 (.clk(clk), .rst(rst), .bus(a2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a0.request = 0; a0.req_addr = '0; a0.result = 0; a0.upd_index = '0; a0.taken = 0;
    a1.request = 0; a1.req_addr = '0; a1.result = 0; a1.upd_index = '0; a1.taken = 0;
    a2.request = 0; a2.req_addr = '0; a2.result = 0; a2.upd_index = '0; a2.taken = 0;
  endtask

  task automatic test_reset();
    idle();
    tick();
    ntot++; if (a0.prediction !== 1'b0) $display("FAIL reset_pred: got %b want 0", a0.prediction); else npass++;
    ntot++; if (a0.pred_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", a0.pred_valid); else npass++;
    ntot++; if (a0.pred_strong !== 1'b0) $display("FAIL reset_strong: got %b want 0", a0.pred_strong); else npass++;
    ntot++; if (a0.pred_index !== 4'd0) $display("FAIL reset_index: got %0d want 0", a0.pred_index); else npass++;
    rst = 1'b0;
  endtask

  task automatic test_predict_default();
    a0.request = 1; a0.req_addr = 32'h40;
    tick();
    a0.request = 0;
    ntot++; if (a0.pred_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", a0.pred_valid); else npass++;
    ntot++; if (a0.prediction !== 1'b1) $display("FAIL first_pred: got %b want 1", a0.prediction); else npass++;
    ntot++; if (a0.pred_strong !== 1'b1) $display("FAIL first_strong: got %b want 1", a0.pred_strong); else npass++;
    ntot++; if (a0.pred_index !== 4'd0) $display("FAIL first_index: got %0d want 0", a0.pred_index); else npass++;
    a0.request = 1; a0.req_addr = 32'h14;
    tick();
    a0.request = 0;
    ntot++; if (a0.pred_index !== 4'd5) $display("FAIL idx5_index: got %0d want 5", a0.pred_index); else npass++;
    tick();
    ntot++; if (a0.pred_valid !== 1'b0) $display("FAIL pulse_once: got %b want 0", a0.pred_valid); else npass++;
    ntot++; if (a0.pred_index !== 4'd5) $display("FAIL hold_index: got %0d want 5", a0.pred_index); else npass++;
  endtask

  task automatic test_saturate();
    a0.result = 1; a0.upd_index = 4'd0; a0.taken = 0;
    tick(); tick();
    a0.result = 0;
    a0.request = 1; a0.req_addr = 32'h40;
    tick();
    a0.request = 0;
    ntot++; if (a0.prediction !== 1'b0) $display("FAIL ctr1_pred: got %b want 0", a0.prediction); else npass++;
    ntot++; if (a0.pred_strong !== 1'b0) $display("FAIL ctr1_strong: got %b want 0", a0.pred_strong); else npass++;
    a0.result = 1; a0.taken = 0;
    tick(); tick(); tick();
    a0.result = 0;
    a0.request = 1;
    tick();
    a0.request = 0;
    ntot++; if (a0.prediction !== 1'b0) $display("FAIL floor_pred: got %b want 0", a0.prediction); else npass++;
    ntot++; if (a0.pred_strong !== 1'b1) $display("FAIL floor_strong: got %b want 1", a0.pred_strong); else npass++;
    a0.result = 1; a0.taken = 1;
    tick(); tick(); tick(); tick();
    a0.result = 0;
    a0.request = 1;
    tick();
    a0.request = 0;
    ntot++; if (a0.prediction !== 1'b1) $display("FAIL ceil_pred: got %b want 1", a0.prediction); else npass++;
    ntot++; if (a0.pred_strong !== 1'b1) $display("FAIL ceil_strong: got %b want 1", a0.pred_strong); else npass++;
    a0.request = 1; a0.req_addr = 32'h14;
    tick();
    a0.request = 0;
    ntot++; if (a0.prediction !== 1'b1) $display("FAIL idx5_untouched: got %b want 1", a0.prediction); else npass++;
  endtask

  task automatic test_same_cycle();
    a0.result = 1; a0.upd_index = 4'd0; a0.taken = 0;
    tick();
    // counter 2: request and not-taken update together
    a0.request = 1; a0.req_addr = 32'h40;
    tick();
    a0.result = 0;
    ntot++; if (a0.prediction !== 1'b1) $display("FAIL same_old_pred: got %b want 1", a0.prediction); else npass++;
    ntot++; if (a0.pred_strong !== 1'b0) $display("FAIL same_old_strong: got %b want 0", a0.pred_strong); else npass++;
    tick();
    a0.request = 0;
    ntot++; if (a0.prediction !== 1'b0) $display("FAIL same_new_pred: got %b want 0", a0.prediction); else npass++;
    ntot++; if (a0.pred_valid !== 1'b1) $display("FAIL same_new_valid: got %b want 1", a0.pred_valid); else npass++;
  endtask

  task automatic test_gshare();
    a1.result = 1; a1.upd_index = 4'd7; a1.taken = 1;
    tick();
    a1.taken = 0;
    tick();
    a1.result = 0;
    a1.request = 1; a1.req_addr = 32'h44;
    a0.request = 1; a0.req_addr = 32'h44;
    tick();
    a0.request = 0;
    ntot++; if (a1.pred_index !== 4'd3) $display("FAIL gshare_index: got %0d want 3", a1.pred_index); else npass++;
    ntot++; if (a0.pred_index !== 4'd1) $display("FAIL bimodal_index: got %0d want 1", a0.pred_index); else npass++;
    // taken update with request: index uses ghr=10, then ghr becomes 01
    a1.result = 1; a1.taken = 1;
    tick();
    a1.result = 0;
    ntot++; if (a1.pred_index !== 4'd3) $display("FAIL gshare_preshift: got %0d want 3", a1.pred_index); else npass++;
    tick();
    a1.request = 0;
    ntot++; if (a1.pred_index !== 4'd0) $display("FAIL gshare_shifted: got %0d want 0", a1.pred_index); else npass++;
  endtask

  task automatic test_wide();
    a2.request = 1; a2.req_addr = 32'h40;
    tick();
    a2.request = 0;
    ntot++; if (a2.prediction !== 1'b0) $display("FAIL wide_init_pred: got %b want 0", a2.prediction); else npass++;
    ntot++; if (a2.pred_strong !== 1'b1) $display("FAIL wide_init_strong: got %b want 1", a2.pred_strong); else npass++;
    a2.result = 1; a2.upd_index = 4'd0; a2.taken = 1;
    tick(); tick(); tick(); tick();
    a2.result = 0;
    a2.request = 1;
    tick();
    a2.request = 0;
    ntot++; if (a2.prediction !== 1'b1) $display("FAIL wide4_pred: got %b want 1", a2.prediction); else npass++;
    ntot++; if (a2.pred_strong !== 1'b0) $display("FAIL wide4_strong: got %b want 0", a2.pred_strong); else npass++;
    a2.result = 1;
    tick(); tick(); tick(); tick();
    a2.result = 0;
    a2.request = 1;
    tick();
    a2.request = 0;
    ntot++; if (a2.prediction !== 1'b1) $display("FAIL wide7_pred: got %b want 1", a2.prediction); else npass++;
    ntot++; if (a2.pred_strong !== 1'b1) $display("FAIL wide7_strong: got %b want 1", a2.pred_strong); else npass++;
  endtask

  task automatic test_mid_reset();
    a0.request = 1; a0.req_addr = 32'h44;
    tick();
    ntot++; if (a0.pred_index !== 4'd1) $display("FAIL prerst_index: got %0d want 1", a0.pred_index); else npass++;
    #2;
    rst = 1'b1;
    #1;
    ntot++; if (a0.prediction !== 1'b0) $display("FAIL async_pred: got %b want 0", a0.prediction); else npass++;
    ntot++; if (a0.pred_valid !== 1'b0) $display("FAIL async_valid: got %b want 0", a0.pred_valid); else npass++;
    ntot++; if (a0.pred_index !== 4'd0) $display("FAIL async_index: got %0d want 0", a0.pred_index); else npass++;
    ntot++; if (a0.pred_strong !== 1'b0) $display("FAIL async_strong: got %b want 0", a0.pred_strong); else npass++;
    // inputs during reset must be discarded
    a0.result = 1; a0.upd_index = 4'd0; a0.taken = 0;
    a1.result = 1; a1.taken = 1;
    tick();
    ntot++; if (a0.pred_valid !== 1'b0) $display("FAIL rst_discard_valid: got %b want 0", a0.pred_valid); else npass++;
    rst = 1'b0;
    idle();
    a0.request = 1; a0.req_addr = 32'h40;
    a1.request = 1; a1.req_addr = 32'h44;
    a2.request = 1; a2.req_addr = 32'h40;
    tick();
    idle();
    ntot++; if (a0.prediction !== 1'b1) $display("FAIL post_a0_pred: got %b want 1", a0.prediction); else npass++;
    ntot++; if (a0.pred_strong !== 1'b1) $display("FAIL post_a0_strong: got %b want 1", a0.pred_strong); else npass++;
    ntot++; if (a1.pred_index !== 4'd1) $display("FAIL post_ghr_index: got %0d want 1", a1.pred_index); else npass++;
    ntot++; if (a2.prediction !== 1'b0) $display("FAIL post_a2_pred: got %b want 0", a2.prediction); else npass++;
  endtask

  initial begin
    test_reset();
    test_predict_default();
    test_saturate();
    test_same_cycle();
    test_gshare();
    test_wide();
    test_mid_reset();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
